// File: rtl/otter_io_harness.sv
// -----------------------------------------------------------------------------
// otter_io_harness
//
// I/O companion for OTTER_MCU. Sequences the MCU reset, serves memory-mapped
// input channels on the IOBUS read path, latches output channel registers,
// records every accepted IOBUS write in a small trace FIFO and optionally
// emits periodic interrupt pulses while the MCU is running.
//
// Address map (word aligned, ADDR[1:0] ignored), relative to BASE_ADDR:
//   0x000 + 4*i : input channel i  (read only)
//   0x100 + 4*j : output channel j (read/write)
//   0x200       : control; read {30'b0, LOG_OVF, running}, write bit0=1 is a
//                 soft reset of the MCU
//
// Ports:
//   CLK, RST_N       system clock (rising edge), async active-low reset
//   IOBUS_ADDR/OUT   MCU address and write data
//   IOBUS_WR         MCU write strobe
//   IOBUS_IN         registered read data (one-cycle latency)
//   MCU_RST          active-high reset to the MCU
//   INTR             single-cycle interrupt pulse
//   IN_CH / OUT_CH   packed 32-bit channels, channel k at [32k+31:32k]
//   LOG_RD           pop one trace entry
//   LOG_DATA         head trace entry {addr, data}, 0 when empty
//   LOG_EMPTY/FULL   trace FIFO status
//   LOG_OVF          sticky: a write was dropped because the trace was full
//
// Sequencer states:
//   state | meaning
//   HOLD  | MCU held in reset, hold counter running
//   RUN   | MCU released, writes accepted, interrupt timer running
// -----------------------------------------------------------------------------
module otter_io_harness #(
  parameter int          NUM_IN_CH   = 4,
  parameter int          NUM_OUT_CH  = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0000,
  parameter int          RST_HOLD    = 3,
  parameter int          LOG_DEPTH   = 8,
  parameter int          INTR_PERIOD = 0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [31:0]             IOBUS_ADDR,
  input  logic [31:0]             IOBUS_OUT,
  input  logic                    IOBUS_WR,
  output logic [31:0]             IOBUS_IN,
  output logic                    MCU_RST,
  output logic                    INTR,
  input  logic [32*NUM_IN_CH-1:0] IN_CH,
  output logic [32*NUM_OUT_CH-1:0] OUT_CH,
  input  logic                    LOG_RD,
  output logic [63:0]             LOG_DATA,
  output logic                    LOG_EMPTY,
  output logic                    LOG_FULL,
  output logic                    LOG_OVF
);

  localparam int PW  = $clog2(LOG_DEPTH);
  localparam int HCW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [HCW-1:0]   hold_cnt, hold_cnt_nxt;

  // ---------------------------------------------------------------------------
  // Address decode. Subtracting the base on the word address makes addresses
  // below the window wrap to huge offsets, so one unsigned compare per region
  // is enough.
  // ---------------------------------------------------------------------------
  logic [29:0] off_word;
  logic        in_hit, out_hit, ctrl_hit;
  logic [3:0]  in_idx, out_idx;

  assign off_word = IOBUS_ADDR[31:2] - BASE_ADDR[31:2];
  assign in_hit   = off_word < 30'(NUM_IN_CH);
  assign out_hit  = (off_word >= 30'd64) && (off_word < 30'(64 + NUM_OUT_CH));
  assign ctrl_hit = off_word == 30'd128;
  assign in_idx   = off_word[3:0];
  assign out_idx  = 4'(off_word - 30'd64);

  logic wr_acc, soft_rst;

  assign wr_acc   = (state == RUN) && IOBUS_WR;
  assign soft_rst = wr_acc && ctrl_hit && IOBUS_OUT[0];

  // ---------------------------------------------------------------------------
  // Reset sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= HOLD;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    MCU_RST      = 1'b1;
    case (state)
      HOLD: begin
        MCU_RST = 1'b1;
        if (hold_cnt == HCW'(RST_HOLD - 1)) begin
          state_nxt    = RUN;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      RUN: begin
        MCU_RST = 1'b0;
        if (soft_rst) begin
          state_nxt    = HOLD;
          hold_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = HOLD;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output channel registers
  // ---------------------------------------------------------------------------
  logic [32*NUM_OUT_CH-1:0] out_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_reg <= '0;
    end else begin
      for (int j = 0; j < NUM_OUT_CH; j++) begin
        if (wr_acc && out_hit && (out_idx == 4'(j))) begin
          out_reg[32*j +: 32] <= IOBUS_OUT;
        end
      end
    end
  end

  assign OUT_CH = out_reg;

  // ---------------------------------------------------------------------------
  // Write trace FIFO
  // ---------------------------------------------------------------------------
  logic [63:0]   log_mem [LOG_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   log_cnt;
  logic          log_ovf_q;
  logic          log_empty, log_full;
  logic          push, pop, ovf_set;

  assign log_empty = (log_cnt == '0);
  assign log_full  = (log_cnt == (PW+1)'(LOG_DEPTH));
  assign pop       = LOG_RD && !log_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = wr_acc && (!log_full || pop);
  assign ovf_set   = wr_acc && log_full && !pop;

  always_ff @(posedge CLK) begin
    if (push) begin
      log_mem[wr_ptr] <= {IOBUS_ADDR, IOBUS_OUT};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      log_cnt   <= '0;
      log_ovf_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   log_cnt <= log_cnt + 1'b1;
        2'b01:   log_cnt <= log_cnt - 1'b1;
        default: log_cnt <= log_cnt;
      endcase
      if (ovf_set) log_ovf_q <= 1'b1;
    end
  end

  // Storage is not reset; gating with empty keeps the head at 0 out of reset.
  assign LOG_DATA  = log_empty ? 64'd0 : log_mem[rd_ptr];
  assign LOG_EMPTY = log_empty;
  assign LOG_FULL  = log_full;
  assign LOG_OVF   = log_ovf_q;

  // ---------------------------------------------------------------------------
  // Registered read path
  // ---------------------------------------------------------------------------
  logic [31:0] rd_data;
  logic [31:0] iobus_in_q;

  always_comb begin
    rd_data = 32'd0;
    for (int i = 0; i < NUM_IN_CH; i++) begin
      if (in_hit && (in_idx == 4'(i))) rd_data = IN_CH[32*i +: 32];
    end
    for (int j = 0; j < NUM_OUT_CH; j++) begin
      if (out_hit && (out_idx == 4'(j))) rd_data = out_reg[32*j +: 32];
    end
    if (ctrl_hit) rd_data = {30'd0, log_ovf_q, (state == RUN)};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      iobus_in_q <= 32'd0;
    end else begin
      iobus_in_q <= rd_data;
    end
  end

  assign IOBUS_IN = iobus_in_q;

  // ---------------------------------------------------------------------------
  // Periodic interrupt. The counter only advances in RUN, so the first pulse
  // lands INTR_PERIOD cycles after the sequencer releases the MCU.
  // ---------------------------------------------------------------------------
  logic intr_q;

  if (INTR_PERIOD > 0) begin : g_intr
    localparam int ICW = (INTR_PERIOD > 1) ? $clog2(INTR_PERIOD) : 1;
    logic [ICW-1:0] intr_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        intr_cnt <= '0;
        intr_q   <= 1'b0;
      end else if (state == RUN) begin
        if (intr_cnt == ICW'(INTR_PERIOD - 1)) begin
          intr_cnt <= '0;
          intr_q   <= 1'b1;
        end else begin
          intr_cnt <= intr_cnt + 1'b1;
          intr_q   <= 1'b0;
        end
      end else begin
        intr_cnt <= '0;
        intr_q   <= 1'b0;
      end
    end
  end else begin : g_no_intr
    assign intr_q = 1'b0;
  end

  assign INTR = intr_q;

endmodule

// File: tb/tb_otter_io_harness.sv
module tb_otter_io_harness;

  localparam int          NI   = 4;
  localparam int          NO   = 4;
  localparam int          RH   = 3;
  localparam int          LD   = 8;
  localparam int          IP   = 5;
  localparam logic [31:0] BASE = 32'h1100_0000;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b1;
  logic [31:0]       IOBUS_ADDR, IOBUS_OUT;
  logic              IOBUS_WR;
  logic [31:0]       IOBUS_IN;
  logic              MCU_RST, INTR;
  logic [32*NI-1:0]  IN_CH;
  logic [32*NO-1:0]  OUT_CH;
  logic              LOG_RD;
  logic [63:0]       LOG_DATA;
  logic              LOG_EMPTY, LOG_FULL, LOG_OVF;

  otter_io_harness #(
    .NUM_IN_CH(NI), .NUM_OUT_CH(NO), .BASE_ADDR(BASE),
    .RST_HOLD(RH), .LOG_DEPTH(LD), .INTR_PERIOD(IP)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR),
    .IOBUS_IN(IOBUS_IN), .MCU_RST(MCU_RST), .INTR(INTR),
    .IN_CH(IN_CH), .OUT_CH(OUT_CH),
    .LOG_RD(LOG_RD), .LOG_DATA(LOG_DATA),
    .LOG_EMPTY(LOG_EMPTY), .LOG_FULL(LOG_FULL), .LOG_OVF(LOG_OVF)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_run;
  int          m_hold_left;
  int          m_run_cycles;
  bit          m_intr;
  logic [31:0] m_rd;
  logic [31:0] m_out [NO];
  bit          m_ovf;
  logic [63:0] m_log [$];
  bit          was_run, acc, popping, was_full;
  int          oi;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    longint unsigned w, b;
    int idx;
    w = longint'(a & 32'hFFFF_FFFC);
    b = longint'(BASE);
    if (w >= b && w < b + 4*NI) begin
      idx = int'((w - b) / 4);
      return IN_CH[32*idx +: 32];
    end
    if (w >= b + 256 && w < b + 256 + 4*NO) return m_out[int'((w - b - 256) / 4)];
    if (w == b + 512) return {30'd0, m_ovf, m_run};
    return 32'd0;
  endfunction

  function automatic int out_index(input logic [31:0] a);
    longint unsigned w, b;
    w = longint'(a & 32'hFFFF_FFFC);
    b = longint'(BASE) + 256;
    if (w >= b && w < b + 4*NO) return int'((w - b) / 4);
    return -1;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_run = 1'b0;
      m_hold_left = RH;
      m_run_cycles = 0;
      m_intr = 1'b0;
      m_rd = 32'd0;
      for (int j = 0; j < NO; j++) m_out[j] = 32'd0;
      m_ovf = 1'b0;
      m_log.delete();
    end else begin
      was_run  = m_run;
      acc      = was_run && IOBUS_WR;
      m_rd     = model_read(IOBUS_ADDR);
      popping  = LOG_RD && (m_log.size() > 0);
      was_full = (m_log.size() == LD);
      if (popping) void'(m_log.pop_front());
      if (acc) begin
        if (!was_full || popping) m_log.push_back({IOBUS_ADDR, IOBUS_OUT});
        else m_ovf = 1'b1;
        oi = out_index(IOBUS_ADDR);
        if (oi >= 0) m_out[oi] = IOBUS_OUT;
      end
      if (was_run) begin
        m_run_cycles++;
        m_intr = (m_run_cycles % IP) == 0;
        if (acc && ((IOBUS_ADDR & 32'hFFFF_FFFC) == BASE + 32'h200) && IOBUS_OUT[0]) begin
          m_run = 1'b0;
          m_hold_left = RH;
        end
      end else begin
        m_intr = 1'b0;
        m_hold_left--;
        if (m_hold_left == 0) begin
          m_run = 1'b1;
          m_run_cycles = 0;
        end
      end
    end
  end

  logic [32*NO-1:0] m_out_packed;

  always @(negedge CLK) begin
    for (int j = 0; j < NO; j++) m_out_packed[32*j +: 32] = m_out[j];
    chk("mcu_rst",   MCU_RST,   !m_run);
    chk("intr",      INTR,      m_intr);
    chk("iobus_in",  IOBUS_IN,  m_rd);
    chk("log_empty", LOG_EMPTY, m_log.size() == 0);
    chk("log_full",  LOG_FULL,  m_log.size() == LD);
    chk("log_ovf",   LOG_OVF,   m_ovf);
    chk("out_ch",    OUT_CH,    m_out_packed);
    if (m_log.size() != 0) chk("log_data", LOG_DATA, m_log[0]);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  int          n, hi;
  logic        intr_hold;
  logic [31:0] mask;

  initial begin
    IOBUS_ADDR = 32'd0;
    IOBUS_OUT  = 32'd0;
    IOBUS_WR   = 1'b0;
    LOG_RD     = 1'b0;
    IN_CH      = {32'h3333_3333, 32'h0000_0002, 32'h1111_1111, 32'hA0A0_0000};
    #1 RST_N = 1'b0;
    #1;
    chk("rst_mcu_rst",   MCU_RST,   1'b1);
    chk("rst_intr",      INTR,      1'b0);
    chk("rst_iobus_in",  IOBUS_IN,  32'd0);
    chk("rst_log_empty", LOG_EMPTY, 1'b1);
    chk("rst_log_full",  LOG_FULL,  1'b0);
    chk("rst_log_data",  LOG_DATA,  64'd0);
    tick;
    tick;
    RST_N = 1'b1;
    n = 0;
    while (MCU_RST && n < 20) begin
      tick;
      n++;
    end
    chk("rst_hold_edges", n, 3);

    // reads
    IOBUS_ADDR = BASE + 32'h8;
    tick;
    chk("rd_in_ch2", IOBUS_IN, 32'h2);
    IOBUS_ADDR = BASE + 32'h6;
    tick;
    chk("rd_in_ch1_lowbits", IOBUS_IN, 32'h1111_1111);
    IOBUS_ADDR = BASE + 32'h300;
    tick;
    chk("rd_unmapped", IOBUS_IN, 32'd0);

    // output write + log
    IOBUS_ADDR = BASE + 32'h104;
    IOBUS_OUT  = 32'hDEAD_BEEF;
    IOBUS_WR   = 1'b1;
    tick;
    IOBUS_WR   = 1'b0;
    chk("wr_out_ch1",   OUT_CH[63:32], 32'hDEAD_BEEF);
    chk("wr_log_data",  LOG_DATA, {BASE + 32'h104, 32'hDEAD_BEEF});
    chk("wr_log_empty", LOG_EMPTY, 1'b0);
    tick;
    chk("rd_out_ch1", IOBUS_IN, 32'hDEAD_BEEF);
    LOG_RD = 1'b1;
    tick;
    LOG_RD = 1'b0;
    chk("pop_to_empty", LOG_EMPTY, 1'b1);

    // fill trace past capacity
    for (int k = 0; k < 9; k++) begin
      IOBUS_ADDR = (k % 3 == 0) ? 32'h2000_0000 + 32'(4*k) : BASE + 32'h100 + 32'(4*(k % 4));
      IOBUS_OUT  = 32'(k);
      IOBUS_WR   = 1'b1;
      tick;
      if (k == 7) begin
        chk("full_after_8", LOG_FULL, 1'b1);
        chk("no_ovf_at_8",  LOG_OVF,  1'b0);
      end
      if (k == 8) chk("ovf_after_9", LOG_OVF, 1'b1);
    end
    IOBUS_WR = 1'b0;
    chk("log_head0", LOG_DATA, {32'h2000_0000, 32'd0});

    // push + pop while full
    IOBUS_ADDR = 32'h3000_0000;
    IOBUS_OUT  = 32'h55;
    IOBUS_WR   = 1'b1;
    LOG_RD     = 1'b1;
    tick;
    IOBUS_WR   = 1'b0;
    LOG_RD     = 1'b0;
    chk("pushpop_full", LOG_FULL, 1'b1);
    chk("log_head1",    LOG_DATA, {BASE + 32'h104, 32'd1});
    IOBUS_ADDR = BASE + 32'h200;
    tick;
    chk("rd_ctrl", IOBUS_IN, 32'd3);

    // drain (ninth pop is on an empty FIFO)
    LOG_RD = 1'b1;
    repeat (9) tick;
    LOG_RD = 1'b0;
    chk("drained", LOG_EMPTY, 1'b1);
    chk("ovf_sticky", LOG_OVF, 1'b1);

    // soft reset
    IOBUS_ADDR = BASE + 32'h200;
    IOBUS_OUT  = 32'd1;
    IOBUS_WR   = 1'b1;
    tick;
    hi = MCU_RST ? 1 : 0;
    IOBUS_ADDR = BASE + 32'h100;
    IOBUS_OUT  = 32'hBAD0_BAD0;
    tick;
    IOBUS_WR  = 1'b0;
    hi       += MCU_RST ? 1 : 0;
    intr_hold = INTR;
    chk("hold_wr_ignored", OUT_CH[31:0], 32'd8);
    chk("softrst_logged",  LOG_DATA, {BASE + 32'h200, 32'd1});
    n = 0;
    while (MCU_RST && n < 10) begin
      tick;
      n++;
      if (MCU_RST) hi++;
      intr_hold |= INTR;
    end
    chk("softrst_hold_cycles", hi, 3);
    chk("no_intr_in_hold", intr_hold, 1'b0);
    chk("out_retained", OUT_CH, {32'd7, 32'd2, 32'd5, 32'd8});
    chk("ovf_kept_softrst", LOG_OVF, 1'b1);

    // interrupt cadence after entering RUN
    IOBUS_ADDR = BASE + 32'h8;
    mask = 32'd0;
    for (int c = 1; c <= 15; c++) begin
      LOG_RD = (c == 1);
      tick;
      LOG_RD = 1'b0;
      if (INTR) mask[c] = 1'b1;
      if (c == 2) chk("hold_write_not_logged", LOG_EMPTY, 1'b1);
    end
    chk("intr_pulses", mask, 32'h0000_8420);

    // async reset mid-run while INTR is high
    #1 RST_N = 1'b0;
    #1;
    chk("async_mcu_rst",  MCU_RST,  1'b1);
    chk("async_intr",     INTR,     1'b0);
    chk("async_iobus_in", IOBUS_IN, 32'd0);
    chk("async_out_ch",   OUT_CH,   128'd0);
    chk("async_log_ovf",  LOG_OVF,  1'b0);
    chk("async_log_empty", LOG_EMPTY, 1'b1);
    tick;
    tick;
    RST_N = 1'b1;
    repeat (6) tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/otter_io_harness.md
Name: otter_io_harness

Overview:
- Synthesizable I/O harness for OTTER_MCU. Replaces hand-written reset/input stimulus with a parametrised block.
- Sequences MCU reset and serves NUM_IN_CH memory-mapped input channels on IOBUS_IN.
- Latches NUM_OUT_CH output channels, logs every IOBUS write into a FIFO, and generates periodic interrupt pulses.
- Sits beside OTTER_MCU on the IOBUS in both FPGA top level and simulation.

Parameters:
- NUM_IN_CH, 4, number of 32-bit input channels (1-16).
- NUM_OUT_CH, 4, number of 32-bit output channels (1-16).
- BASE_ADDR, 32'h1100_0000, base of I/O window.
- RST_HOLD, 3, cycles MCU_RST is held high after reset release or soft reset (>=1).
- LOG_DEPTH, 8, write-log FIFO entries (power of 2, >=2).
- INTR_PERIOD, 0, cycles between INTR pulses while running; 0 disables.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IOBUS_ADDR  in  32  MCU I/O address.
- IOBUS_OUT  in  32  MCU write data.
- IOBUS_WR  in  1  MCU write strobe, one cycle per store.
- IOBUS_IN  out  32  read data to MCU.
- MCU_RST  out  1  active-high reset to OTTER_MCU.
- INTR  out  1  interrupt pulse to OTTER_MCU.
- IN_CH  in  32*NUM_IN_CH  external input values; channel i at bits [32i+31:32i].
- OUT_CH  out  32*NUM_OUT_CH  output channel registers, same packing.
- LOG_RD  in  1  pop one log entry.
- LOG_DATA  out  64  head entry {addr[31:0], data[31:0]}; valid when !LOG_EMPTY.
- LOG_EMPTY  out  1  log FIFO empty.
- LOG_FULL  out  1  log FIFO full.
- LOG_OVF  out  1  sticky: write dropped because log was full.

Behaviour:
- Reset (RST_N=0, async): state=HOLD, hold counter=0, MCU_RST=1, INTR=0, IOBUS_IN=0, OUT_CH all 0, FIFO empty (LOG_EMPTY=1, LOG_FULL=0), LOG_OVF=0, LOG_DATA=0, interrupt counter=0.
- Address map, word-aligned, ADDR[1:0] ignored:
  - Input ch i: BASE_ADDR+4*i.
  - Output ch j: BASE_ADDR+0x100+4*j.
  - Control: BASE_ADDR+0x200.
- Sequencer FSM:
  - HOLD: MCU_RST=1; counter increments each cycle; at count RST_HOLD-1 go to RUN next cycle. MCU_RST is therefore high for exactly RST_HOLD cycles after RST_N rises.
  - RUN: MCU_RST=0.
  - In RUN, IOBUS_WR to control address with IOBUS_OUT[0]=1 is a soft reset: next state HOLD, counter=0.
  - Soft reset does not clear OUT_CH, the log, or LOG_OVF. The soft-reset write itself is logged.
- Reads: IOBUS_IN is registered, one-cycle latency: IOBUS_IN(t+1) = value selected by IOBUS_ADDR(t).
  - Input address returns IN_CH channel.
  - Output address returns current OUT_CH value.
  - Control address returns {30'b0, LOG_OVF, state==RUN}.
  - Unmapped addresses return 0.
- Writes, accepted only in RUN with IOBUS_WR=1; writes in HOLD are ignored and not logged:
  - Output address: OUT_CH[j] <= IOBUS_OUT, visible next cycle.
  - Input or unmapped address: no register effect, but still logged.
  - Addresses outside the window are also logged; the log is a full bus trace.
- Log FIFO: each accepted write pushes {IOBUS_ADDR, IOBUS_OUT}.
  - LOG_DATA is the head entry, combinational from storage; LOG_RD pops.
  - Pop while empty: ignored.
  - Push while full with no pop: dropped, LOG_OVF<=1, sticky until RST_N.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: push succeeds, pop ignored.
  - Pointers wrap modulo LOG_DEPTH. Full/empty come from a count of width clog2(LOG_DEPTH)+1.
- Interrupt: when INTR_PERIOD>0, a counter runs in RUN only and is cleared in HOLD. INTR=1 for one cycle when counter reaches INTR_PERIOD-1, then counter returns to 0. First pulse occurs INTR_PERIOD cycles after entering RUN. INTR is registered.
- RST_N asserted mid-operation: everything returns to reset values immediately, with no waiting for a clock edge.

Test Plan:
- Release RST_N, RST_HOLD=3 -> MCU_RST high exactly 3 CLK rising edges after release, then 0; IOBUS_IN=0; LOG_EMPTY=1.
- IN_CH ch2=32'h0000_0002, IOBUS_ADDR=BASE_ADDR+8 -> IOBUS_IN=32'h2 one cycle later; address BASE_ADDR+0x300 -> IOBUS_IN=0.
- Write 32'hDEAD_BEEF to BASE_ADDR+0x104 in RUN -> OUT_CH ch1=32'hDEADBEEF next cycle; LOG_DATA={BASE_ADDR+0x104, 32'hDEADBEEF}; LOG_EMPTY=0.
- 9 writes with LOG_DEPTH=8, no pops -> LOG_FULL=1 after 8th, LOG_OVF=1 after 9th. Then push+pop in the same cycle -> count stays 8, second entry now at head.
- Write 1 to BASE_ADDR+0x200 -> MCU_RST high for RST_HOLD cycles; OUT_CH retained; a write issued during HOLD is neither applied nor logged.
- INTR_PERIOD=5 -> single-cycle INTR pulses on cycles 5, 10, 15 after entering RUN; none in HOLD. RST_N pulse low mid-run -> INTR=0, MCU_RST=1 immediately.
